fe_transmit: RTL

UTMI+ transmit engine for the PhyWhisperer front end. It drives the PHY's transmit side: fe_txvalid, the fe_data output path and the opmode pins. It replays a host-loaded packet onto the bus as PID, optional payload and optional USB CRC16, using the UTMI fe_txrdy handshake. It runs entirely in the fe_clk domain. The top level uses its outputs in place of the constant fe_txvalid, fe_opmode and fe_data tie-offs.

---
 rtl/fe_transmit.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fe_transmit.sv
// UTMI+ transmit engine: replays a host-loaded packet (PID, payload, optional CRC16)
// onto the PHY transmit interface using the fe_txrdy handshake, all in the fe_clk domain.
module fe_transmit #(
    parameter int pBUFFER_BYTES  = 64,
    parameter int pLEN_WIDTH     = 7,
    parameter int pSETUP_CYCLES  = 2,
    parameter int pTXRDY_TIMEOUT = 1024
) (
    input  logic                  fe_clk,
    input  logic                  reset_i,
    input  logic                  I_load_clear,
    input  logic [7:0]            I_load_data,
    input  logic                  I_load_wr,
    output logic [pLEN_WIDTH-1:0] O_load_count,
    input  logic [3:0]            I_pid,
    input  logic [pLEN_WIDTH-1:0] I_len,
    input  logic                  I_crc_en,
    input  logic                  I_start,
    input  logic                  fe_txrdy,
    output logic                  fe_txvalid,
    output logic [7:0]            O_fe_data,
    output logic                  O_fe_data_oe,
    output logic [1:0]            O_opmode,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_error
);

    localparam int ADDR_W  = (pBUFFER_BYTES > 1) ? $clog2(pBUFFER_BYTES) : 1;
    localparam int SETUP_W = (pSETUP_CYCLES > 1) ? $clog2(pSETUP_CYCLES) : 1;
    localparam int TMO_W   = (pTXRDY_TIMEOUT > 1) ? $clog2(pTXRDY_TIMEOUT) : 1;

    localparam logic [pLEN_WIDTH-1:0] BUF_MAX     = pLEN_WIDTH'(pBUFFER_BYTES);
    localparam logic [SETUP_W-1:0]    SETUP_LAST  = SETUP_W'(pSETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST    = TMO_W'(pTXRDY_TIMEOUT - 1);
    localparam logic [1:0]            OPMODE_IDLE = 2'b01;
    localparam logic [1:0]            OPMODE_TX   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PID    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC_LO = 3'd4,
        ST_CRC_HI = 3'd5,
        ST_HOLD   = 3'd6
    } state_t;

    // USB CRC16, reflected polynomial 0x8005 (0xA001), one byte LSB-first
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    state_t                  state_r;
    logic [7:0]              mem_r [pBUFFER_BYTES];
    logic [pLEN_WIDTH-1:0]   load_count_r;
    logic [pLEN_WIDTH-1:0]   rd_ptr_r;
    logic [pLEN_WIDTH-1:0]   rd_ptr_next_s;
    logic [7:0]              rd_data_r;
    logic [3:0]              pid_r;
    logic [pLEN_WIDTH-1:0]   len_r;
    logic                    crc_en_r;
    logic [15:0]             crc_r;
    logic [15:0]             crc_next_s;
    logic [SETUP_W-1:0]      setup_cnt_r;
    logic [TMO_W-1:0]        wait_cnt_r;
    logic                    abort_r;
    logic                    txvalid_r;
    logic [7:0]              data_r;
    logic                    oe_r;
    logic [1:0]              opmode_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;
    logic                    wr_en_s;
    logic                    accept_s;
    logic                    timeout_s;
    logic                    last_data_s;
    logic                    advance_s;

    assign fe_txvalid   = txvalid_r;
    assign O_fe_data    = data_r;
    assign O_fe_data_oe = oe_r;
    assign O_opmode     = opmode_r;
    assign O_busy       = busy_r;
    assign O_done       = done_r;
    assign O_error      = error_r;
    assign O_load_count = load_count_r;

    assign wr_en_s     = reset_i && (state_r == ST_IDLE) && I_load_wr && !I_load_clear
                         && (load_count_r < BUF_MAX);
    assign accept_s    = txvalid_r && fe_txrdy;
    assign timeout_s   = txvalid_r && !fe_txrdy && (wait_cnt_r == TMO_LAST);
    assign last_data_s = (rd_ptr_r == len_r);
    assign crc_next_s  = crc16_update(crc_r, data_r);
    // The pointer moves whenever the byte it fetched is consumed, keeping rd_data_r one byte ahead
    assign advance_s   = accept_s && (((state_r == ST_PID) && (len_r != {pLEN_WIDTH{1'b0}}))
                                      || ((state_r == ST_DATA) && !last_data_s));

    // Next read address for the payload buffer; rewinds to 0 while idle
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        if (state_r == ST_IDLE) begin
            rd_ptr_next_s = {pLEN_WIDTH{1'b0}};
        end else if (advance_s) begin
            rd_ptr_next_s = rd_ptr_r + pLEN_WIDTH'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Payload buffer storage with registered read of the next byte to send
    always_ff @(posedge fe_clk) begin
        if (wr_en_s) begin
            mem_r[load_count_r[ADDR_W-1:0]] <= I_load_data;
        end
        rd_data_r <= mem_r[rd_ptr_next_s[ADDR_W-1:0]];
    end

    // Read pointer register
    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            rd_ptr_r <= {pLEN_WIDTH{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
        end
    end

    // Loader write pointer / byte count; clear wins over write, frozen while busy
    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            load_count_r <= {pLEN_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && I_load_clear) begin
            load_count_r <= {pLEN_WIDTH{1'b0}};
        end else if (wr_en_s) begin
            load_count_r <= load_count_r + pLEN_WIDTH'(1);
        end
    end

    // Transmit sequencer with registered UTMI outputs
    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            state_r     <= ST_IDLE;
            pid_r       <= 4'h0;
            len_r       <= {pLEN_WIDTH{1'b0}};
            crc_en_r    <= 1'b0;
            crc_r       <= 16'hFFFF;
            setup_cnt_r <= {SETUP_W{1'b0}};
            wait_cnt_r  <= {TMO_W{1'b0}};
            abort_r     <= 1'b0;
            txvalid_r   <= 1'b0;
            data_r      <= 8'h00;
            oe_r        <= 1'b0;
            opmode_r    <= OPMODE_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (I_start) begin
                        if ((I_len > load_count_r) || (I_len > BUF_MAX)) begin
                            error_r <= 1'b1;
                        end else begin
                            pid_r       <= I_pid;
                            len_r       <= I_len;
                            crc_en_r    <= I_crc_en;
                            crc_r       <= 16'hFFFF;
                            setup_cnt_r <= {SETUP_W{1'b0}};
                            abort_r     <= 1'b0;
                            opmode_r    <= OPMODE_TX;
                            oe_r        <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt_r == SETUP_LAST) begin
                        txvalid_r  <= 1'b1;
                        data_r     <= {~pid_r, pid_r};
                        wait_cnt_r <= {TMO_W{1'b0}};
                        state_r    <= ST_PID;
                    end else begin
                        setup_cnt_r <= setup_cnt_r + SETUP_W'(1);
                    end
                end
                ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI: begin
                    if (accept_s) begin
                        wait_cnt_r <= {TMO_W{1'b0}};
                        case (state_r)
                            ST_PID: begin
                                if (len_r != {pLEN_WIDTH{1'b0}}) begin
                                    data_r  <= rd_data_r;
                                    state_r <= ST_DATA;
                                end else if (crc_en_r) begin
                                    data_r  <= ~crc_r[7:0];
                                    state_r <= ST_CRC_LO;
                                end else begin
                                    txvalid_r   <= 1'b0;
                                    setup_cnt_r <= {SETUP_W{1'b0}};
                                    state_r     <= ST_HOLD;
                                end
                            end
                            ST_DATA: begin
                                crc_r <= crc_next_s;
                                if (!last_data_s) begin
                                    data_r <= rd_data_r;
                                end else if (crc_en_r) begin
                                    data_r  <= ~crc_next_s[7:0];
                                    state_r <= ST_CRC_LO;
                                end else begin
                                    txvalid_r   <= 1'b0;
                                    setup_cnt_r <= {SETUP_W{1'b0}};
                                    state_r     <= ST_HOLD;
                                end
                            end
                            ST_CRC_LO: begin
                                data_r  <= ~crc_r[15:8];
                                state_r <= ST_CRC_HI;
                            end
                            default: begin
                                txvalid_r   <= 1'b0;
                                setup_cnt_r <= {SETUP_W{1'b0}};
                                state_r     <= ST_HOLD;
                            end
                        endcase
                    end else if (timeout_s) begin
                        txvalid_r   <= 1'b0;
                        abort_r     <= 1'b1;
                        setup_cnt_r <= {SETUP_W{1'b0}};
                        state_r     <= ST_HOLD;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TMO_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (setup_cnt_r == SETUP_LAST) begin
                        opmode_r <= OPMODE_IDLE;
                        oe_r     <= 1'b0;
                        data_r   <= 8'h00;
                        busy_r   <= 1'b0;
                        done_r   <= !abort_r;
                        error_r  <= abort_r;
                        state_r  <= ST_IDLE;
                    end else begin
                        setup_cnt_r <= setup_cnt_r + SETUP_W'(1);
                    end
                end
                default: begin
                    txvalid_r <= 1'b0;
                    oe_r      <= 1'b0;
                    opmode_r  <= OPMODE_IDLE;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
